gpio_mulpop: RTL and testbench
==============================

// Module: gpio_mulpop
//
// PURPOSE
// Bus-mapped multiply/popcount peripheral for the GPIO emulator subsystem.
// Two OP_W-bit operands are written over the srd/swr bus and multiplied with an
// OP_W-cycle shift-add engine. The low DATA_W bits of the product are popcounted.
// Results, status and a completed-operation counter are exposed on the bus and on
// gpio_out. Fully synchronous to clk; bus strobes are sampled, not used as clocks.
//
// PARAMETERS
// OP_W       24        operand width (2..DATA_W)
// DATA_W     32        bus data width; W result width
// ADDR_W     16        bus address width
// CNT_W      16        completed-operation counter width (<= DATA_W)
// ADDR_A1    16'h037F  operand 1 (write only)
// ADDR_A2    16'h0388  operand 2 (write only)
// ADDR_W     16'h0390  product low DATA_W bits (read only)
// ADDR_L     16'h0398  popcount of W (read only)
// ADDR_CTRL  16'h03A0  write = start; read = status
//
// PORTS
// clk            in   1       single clock, rising edge
// n_reset        in   1       asynchronous active-low reset
// saddress       in   ADDR_W  bus address, valid with srd/swr
// srd            in   1       read strobe, level, may span many clk
// swr            in   1       write strobe, level, may span many clk
// sdata_in       in   DATA_W  write data
// sdata_out      out  DATA_W  read data, registered
// gpio_in        in   DATA_W  raw GPIO inputs
// gpio_latch     in   1       capture gpio_in on rising edge
// gpio_out       out  DATA_W  {zero, op_count[CNT_W-1:0]}
// gpio_in_s_insp out  DATA_W  latched gpio_in, for inspection
//
// BEHAVIOUR
// - Reset: all registers 0, including sdata_out, gpio_out, gpio_in_s_insp,
//   A1, A2, W, L and op_count. Status = {busy=0, done=0, valid=1}. State IDLE.
// - Strobes: srd, swr and gpio_latch are registered once. An action fires on the
//   first clk where the registered value is 0 and the input is 1, so it fires
//   once per strobe. Address and data are sampled in that same cycle.
// - Write A1/A2: stores sdata_in[OP_W-1:0]. Ignored while busy.
// - Write CTRL with sdata_in[0]=1 while not busy: done<=0, busy<=1, go to MULT.
//   Any other CTRL write is ignored. A start while busy sets sticky err (status[3]);
//   a new accepted start clears err.
// - Status read layout: {0, err[3], busy[2], done[1], valid[0]}.
// - FSM: IDLE -> MULT (OP_W cycles) -> POP (1 cycle) -> FIN (1 cycle) -> IDLE.
//   MULT: the accumulator is 2*OP_W bits; each cycle adds the shifted A1 if the
//   current bit of A2 is 1.
//   POP: W <= acc[DATA_W-1:0]; valid <= (acc[2*OP_W-1:DATA_W] == 0), or valid=1
//   when 2*OP_W <= DATA_W.
//   FIN: L <= popcount(W), zero-extended; busy<=0; done<=1; op_count increments
//   and wraps modulo 2^CNT_W.
// - Start to done = OP_W+2 clk after the start edge is detected.
// - Read: sdata_out is updated 1 clk after the srd edge and holds until the next
//   read. W and L read their last completed values, including while busy.
//   An unmapped address, or a read of A1/A2, returns 0.
// - Simultaneous srd and swr edges are both serviced. A read of CTRL in the same
//   cycle as an accepted start returns the pre-start status.
// - Operands are copied at start; A1/A2 writes during MULT are rejected, so the
//   result is never corrupted.
// - Reset mid-operation aborts immediately; done=0 and W/L = 0 after reset.
// - gpio_latch edge: gpio_in_s <= gpio_in.
//
// STRUCTURE
// - gpioemu_pkg: address localparams, state enum {IDLE,MULT,POP,FIN},
//   status bit indices.
// - Sub-module mulpop_core: shift-add multiplier plus popcount with start/done
//   handshake. gpio_mulpop keeps the bus decode, edge detection, registers
//   and counter.
//
// TESTING
// - Reset: after release, read CTRL -> 0x1; read W, L and gpio_out -> 0.
// - A1=3, A2=5, start -> done after OP_W+2 clk; W=15, L=4, status=0x3,
//   gpio_out=1.
// - A1=A2=24'hFFFFFF -> W=32'hFE000001, L=8, valid=0, status=0x2.
// - Start, then mid-MULT write A1=0 and start again -> err set, W unchanged by
//   the A1 write; next start clears err.
// - Swr held high for 10 clk on CTRL -> exactly one operation, op_count +1.
//   Force op_count to 16'hFFFF, run one operation -> gpio_out=0.
// - Assert n_reset during MULT -> status=0x1, W=0. gpio_latch pulse with
//   gpio_in=32'hA5A5_0F0F -> gpio_in_s_insp matches 2 clk later.

Source files
------------

// File: rtl/gpioemu_pkg.sv
// Shared constants, state encoding and helpers for the GPIO emulator
// multiply/popcount peripheral.
package gpioemu_pkg;

  localparam int unsigned OP_W   = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned MCNT_W = $clog2(OP_W);

  localparam logic [ADDR_W-1:0] ADDR_A1   = 16'h037F;
  localparam logic [ADDR_W-1:0] ADDR_A2   = 16'h0388;
  localparam logic [ADDR_W-1:0] ADDR_WRES = 16'h0390;
  localparam logic [ADDR_W-1:0] ADDR_L    = 16'h0398;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 16'h03A0;

  localparam int unsigned ST_VALID = 0;
  localparam int unsigned ST_DONE  = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_ERR   = 3;

  typedef enum logic [1:0] {IDLE, MULT, POP, FIN} state_e;

  function automatic logic [DATA_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) n = n + DATA_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gpio_mulpop_core.sv
// Shift-add multiplier followed by a popcount of the low DATA_W product bits.
// Holds the last completed result until the next operation finishes.
module mulpop_core
  import gpioemu_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic              busy_o,
  output logic              fin_o,
  output logic [DATA_W-1:0] w_o,
  output logic [DATA_W-1:0] l_o,
  output logic              valid_o
);

  state_e              state_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   mcand_q;
  logic [OP_W-1:0]     mplier_q;
  logic [MCNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   w_q;
  logic [DATA_W-1:0]   l_q;
  logic                valid_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      w_q      <= '0;
      l_q      <= '0;
      valid_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= PROD_W'(a_i);
            mplier_q <= b_i;
            cnt_q    <= '0;
            state_q  <= MULT;
          end
        end
        MULT: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + MCNT_W'(1);
          if (cnt_q == MCNT_W'(OP_W - 1)) state_q <= POP;
        end
        POP: begin
          // High product bits beyond the bus width mark the result as truncated
          w_q     <= DATA_W'(acc_q);
          valid_q <= ((acc_q >> DATA_W) == '0);
          state_q <= FIN;
        end
        FIN: begin
          l_q     <= popcount(w_q);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign fin_o   = (state_q == FIN);
  assign w_o     = w_q;
  assign l_o     = l_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/gpio_mulpop.sv
// Bus-mapped multiply/popcount peripheral: strobe edge detection, register
// decode, status and completed-operation counter around mulpop_core.
module gpio_mulpop
  import gpioemu_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] saddress,
  input  logic              srd,
  input  logic              swr,
  input  logic [DATA_W-1:0] sdata_in,
  output logic [DATA_W-1:0] sdata_out,
  input  logic [DATA_W-1:0] gpio_in,
  input  logic              gpio_latch,
  output logic [DATA_W-1:0] gpio_out,
  output logic [DATA_W-1:0] gpio_in_s_insp
);

  logic              srd_q, swr_q, latch_q;
  logic [OP_W-1:0]   a1_q, a2_q;
  logic              done_q, err_q;
  logic [CNT_W-1:0]  op_count_q;
  logic [DATA_W-1:0] sdata_out_q;
  logic [DATA_W-1:0] gpio_in_s_q;

  logic              rd_fire, wr_fire, latch_fire;
  logic              start_req, busy, fin, valid;
  logic [DATA_W-1:0] core_w, core_l, status, rd_data;
  logic              unused_bits;

  assign rd_fire    = srd & ~srd_q;
  assign wr_fire    = swr & ~swr_q;
  assign latch_fire = gpio_latch & ~latch_q;
  assign start_req  = wr_fire && (saddress == ADDR_CTRL) && sdata_in[0];
  assign unused_bits = ^sdata_in[DATA_W-1:OP_W];

  mulpop_core u_core (
    .clk     (clk),
    .n_reset (n_reset),
    .start_i (start_req && !busy),
    .a_i     (a1_q),
    .b_i     (a2_q),
    .busy_o  (busy),
    .fin_o   (fin),
    .w_o     (core_w),
    .l_o     (core_l),
    .valid_o (valid)
  );

  always_comb begin
    status           = '0;
    status[ST_ERR]   = err_q;
    status[ST_BUSY]  = busy;
    status[ST_DONE]  = done_q;
    status[ST_VALID] = valid;
  end

  // Read mux; operand registers are write-only and read back as zero
  always_comb begin
    rd_data = '0;
    case (saddress)
      ADDR_WRES: rd_data = core_w;
      ADDR_L:    rd_data = core_l;
      ADDR_CTRL: rd_data = status;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      srd_q       <= 1'b0;
      swr_q       <= 1'b0;
      latch_q     <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      op_count_q  <= '0;
      sdata_out_q <= '0;
      gpio_in_s_q <= '0;
    end else begin
      srd_q   <= srd;
      swr_q   <= swr;
      latch_q <= gpio_latch;
      if (latch_fire) gpio_in_s_q <= gpio_in;
      if (rd_fire) sdata_out_q <= rd_data;
      if (wr_fire && !busy) begin
        if (saddress == ADDR_A1) a1_q <= sdata_in[OP_W-1:0];
        if (saddress == ADDR_A2) a2_q <= sdata_in[OP_W-1:0];
      end
      if (start_req) begin
        if (busy) begin
          err_q <= 1'b1;
        end else begin
          err_q  <= 1'b0;
          done_q <= 1'b0;
        end
      end
      if (fin) begin
        done_q     <= 1'b1;
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign sdata_out      = sdata_out_q;
  assign gpio_out       = DATA_W'(op_count_q);
  assign gpio_in_s_insp = gpio_in_s_q;

endmodule

// File: tb/tb_gpio_mulpop.sv
// Randomised scoreboard bench for gpio_mulpop against an arithmetic reference model.
module tb_gpio_mulpop;
  import gpioemu_pkg::*;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic [ADDR_W-1:0] saddress = '0;
  logic              srd = 1'b0;
  logic              swr = 1'b0;
  logic [DATA_W-1:0] sdata_in = '0;
  logic [DATA_W-1:0] sdata_out;
  logic [DATA_W-1:0] gpio_in = '0;
  logic              gpio_latch = 1'b0;
  logic [DATA_W-1:0] gpio_out;
  logic [DATA_W-1:0] gpio_in_s_insp;

  always #5 clk = ~clk;

  gpio_mulpop dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] exp_q[$];
  string             name_q[$];

  // reference model state
  logic [OP_W-1:0]   m_a1, m_a2;
  logic [DATA_W-1:0] m_w, m_l;
  bit                m_valid, m_done, m_err, m_busy;
  int unsigned       m_cnt;
  longint unsigned   m_pend;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_status();
    return DATA_W'({m_err, m_busy, m_done, m_valid});
  endfunction

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0; m_w = '0; m_l = '0;
    m_valid = 1'b1; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    m_cnt = 0; m_pend = 0;
  endtask

  task automatic model_start();
    if (m_busy) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0; m_done = 1'b0; m_busy = 1'b1;
      m_pend = 64'(m_a1) * 64'(m_a2);
      start_cyc = cyc + 1;
    end
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    if (addr == ADDR_A1 && !m_busy) m_a1 = data[OP_W-1:0];
    if (addr == ADDR_A2 && !m_busy) m_a2 = data[OP_W-1:0];
    if (addr == ADDR_CTRL && data[0]) model_start();
  endtask

  // Result becomes visible OP_W+2 clocks after the start edge
  task automatic wait_done();
    while (cyc < start_cyc + OP_W + 2) @(negedge clk);
    m_w     = m_pend[DATA_W-1:0];
    m_l     = DATA_W'($countones(m_w));
    m_valid = ((m_pend >> DATA_W) == 0);
    m_busy  = 1'b0;
    m_done  = 1'b1;
    m_cnt   = (m_cnt + 1) % 65536;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    saddress = addr; sdata_in = data; swr = 1'b1;
    model_write(addr, data);
    @(negedge clk); swr = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp, input string name);
    exp_q.push_back(exp); name_q.push_back(name);
    saddress = addr; srd = 1'b1;
    @(negedge clk); srd = 1'b0;
    @(negedge clk);
  endtask

  task automatic rw_ctrl_start();
    exp_q.push_back(m_status()); name_q.push_back("rw_same_cycle_status");
    saddress = ADDR_CTRL; sdata_in = 32'h1; srd = 1'b1; swr = 1'b1;
    model_write(ADDR_CTRL, 32'h1);
    @(negedge clk); srd = 1'b0; swr = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [OP_W-1:0] a1, input logic [OP_W-1:0] a2, input string tag);
    bus_write(ADDR_A1, DATA_W'(a1));
    bus_write(ADDR_A2, DATA_W'(a2));
    bus_write(ADDR_CTRL, 32'h1);
    wait_done();
    bus_read(ADDR_WRES, m_w, {tag, "_w"});
    bus_read(ADDR_L, m_l, {tag, "_l"});
    bus_read(ADDR_CTRL, m_status(), {tag, "_status"});
    check({tag, "_gpio_out"}, gpio_out, DATA_W'(m_cnt));
  endtask

  // Monitor: each detected read edge presents sdata_out one clock later
  initial begin : monitor
    bit srd_p;
    bit fire;
    logic [DATA_W-1:0] e;
    string nm;
    srd_p = 1'b0;
    forever begin
      @(posedge clk);
      fire  = srd && !srd_p && n_reset;
      srd_p = srd;
      if (fire) begin
        #1;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_unexpected: got %h expected no read", sdata_out);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, sdata_out, e);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [OP_W-1:0]   ra, rb;
    logic [ADDR_W-1:0] ua;
    model_reset();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    bus_read(ADDR_CTRL, 32'h1, "reset_status");
    bus_read(ADDR_WRES, '0, "reset_w");
    bus_read(ADDR_L, '0, "reset_l");
    check("reset_gpio_out", gpio_out, '0);
    check("reset_gpio_in_s", gpio_in_s_insp, '0);

    // latency: busy on the last cycle before done, done afterwards
    bus_write(ADDR_A1, 32'd3);
    bus_write(ADDR_A2, 32'd5);
    bus_write(ADDR_CTRL, 32'h1);
    while (cyc < start_cyc + OP_W + 1) @(negedge clk);
    bus_read(ADDR_CTRL, m_status(), "latency_busy");
    wait_done();
    bus_read(ADDR_CTRL, m_status(), "latency_done");
    bus_read(ADDR_WRES, m_w, "mul3x5_w");
    bus_read(ADDR_L, m_l, "mul3x5_l");
    check("mul3x5_gpio_out", gpio_out, DATA_W'(m_cnt));

    run_op(24'hFFFFFF, 24'hFFFFFF, "maxop");

    // operand write and restart during MULT are rejected; err is sticky
    bus_write(ADDR_A1, 32'd7);
    bus_write(ADDR_A2, 32'd9);
    bus_write(ADDR_CTRL, 32'h1);
    bus_write(ADDR_A1, 32'd0);
    bus_write(ADDR_CTRL, 32'h1);
    bus_read(ADDR_WRES, m_w, "busy_w_old");
    bus_read(ADDR_CTRL, m_status(), "busy_status_err");
    wait_done();
    bus_read(ADDR_CTRL, m_status(), "err_sticky_status");
    bus_read(ADDR_WRES, m_w, "err_w");
    bus_write(ADDR_CTRL, 32'h1);
    wait_done();
    bus_read(ADDR_CTRL, m_status(), "err_cleared_status");
    bus_read(ADDR_WRES, m_w, "err_clear_w");

    // write strobe held for 10 clocks starts exactly one operation
    saddress = ADDR_CTRL; sdata_in = 32'h1; swr = 1'b1;
    model_start();
    repeat (10) @(negedge clk);
    swr = 1'b0;
    @(negedge clk);
    wait_done();
    repeat (OP_W) @(negedge clk);
    check("held_swr_count", gpio_out, DATA_W'(m_cnt));
    bus_read(ADDR_CTRL, m_status(), "held_swr_status");

    // counter wrap
    force dut.op_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    check("forced_count", gpio_out, DATA_W'(m_cnt));
    bus_write(ADDR_CTRL, 32'h1);
    release dut.op_count_q;
    wait_done();
    check("count_wrap", gpio_out, DATA_W'(m_cnt));

    // simultaneous read and start on CTRL sees the pre-start status
    bus_write(ADDR_A1, 32'h00_1234);
    bus_write(ADDR_A2, 32'h00_0101);
    rw_ctrl_start();
    wait_done();
    bus_read(ADDR_WRES, m_w, "rw_w");

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = OP_W'($urandom); rb = OP_W'($urandom); end
        1: begin ra = OP_W'($urandom_range(0, 65535)); rb = OP_W'($urandom_range(0, 65535)); end
        2: begin ra = '0; rb = OP_W'($urandom); end
        default: begin ra = OP_W'($urandom); rb = OP_W'($urandom_range(0, 255)); end
      endcase
      bus_write(ADDR_A1, {8'($urandom), ra});
      bus_write(ADDR_A2, {8'($urandom), rb});
      bus_write(ADDR_CTRL, 32'h1);
      if ($urandom_range(0, 1) == 1) bus_read(ADDR_L, m_l, "rand_busy_l");
      if ($urandom_range(0, 1) == 1) bus_write(ADDR_A2, DATA_W'($urandom));
      ua = ADDR_W'($urandom);
      if (ua == ADDR_WRES || ua == ADDR_L || ua == ADDR_CTRL) ua = 16'h0001;
      bus_read(ua, '0, "rand_unmapped");
      wait_done();
      bus_read(ADDR_A1, '0, "rand_a1_readback");
      bus_read(ADDR_WRES, m_w, "rand_w");
      bus_read(ADDR_L, m_l, "rand_l");
      bus_read(ADDR_CTRL, m_status(), "rand_status");
      check("rand_gpio_out", gpio_out, DATA_W'(m_cnt));
    end

    // gpio capture on the latch edge only
    gpio_in = 32'hA5A5_0F0F; gpio_latch = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("gpio_latch", gpio_in_s_insp, 32'hA5A5_0F0F);
    gpio_in = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("gpio_latch_held", gpio_in_s_insp, 32'hA5A5_0F0F);
    gpio_latch = 1'b0;
    @(negedge clk);

    // reset during MULT aborts the operation
    bus_write(ADDR_A1, 32'd11);
    bus_write(ADDR_A2, 32'd13);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    @(negedge clk);
    bus_read(ADDR_CTRL, 32'h1, "midreset_status");
    bus_read(ADDR_WRES, '0, "midreset_w");
    bus_read(ADDR_L, '0, "midreset_l");
    check("midreset_gpio_out", gpio_out, '0);
    check("midreset_gpio_in_s", gpio_in_s_insp, '0);
    run_op(24'd6, 24'd7, "post_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_drain", DATA_W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
